// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates three burst requesters (0=fc, 1=cv, 2=mp) onto a
//               single beat-oriented memory port. A winner is chosen in IDLE
//               and owns the port for its whole burst of len+1 beats.
//               Write bursts end when every beat has been issued. Read bursts
//               end when every beat has been issued and returned.
// Ports       : clk, rst_n (async, active-low)
//               req/we/addr/len/wdata : packed per-requester burst requests
//               gnt/ack/rvalid/rdata  : requester-side status and read data
//               m_req/m_we/m_addr/m_wdata/m_ready/m_rvalid/m_rdata : memory
// Config      : ARB_FIXED_PRIO_EN defined   -> fixed priority cv > fc > mp
//               ARB_FIXED_PRIO_EN undefined -> round-robin after last owner
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [2:0]  we,
  input  logic [80:0] addr,
  input  logic [23:0] len,
  input  logic [95:0] wdata,
  output logic [2:0]  gnt,
  output logic [2:0]  ack,
  output logic [2:0]  rvalid,
  output logic [31:0] rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [26:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_q,    state_d;
  logic [1:0]  owner_q,    owner_d;
  logic        we_q,       we_d;
  logic [26:0] addr_q,     addr_d;
  logic [8:0]  beats_q,    beats_d;
  logic [8:0]  issued_q,   issued_d;
  logic [8:0]  returned_q, returned_d;

  logic [1:0]  winner;
  logic        busy;
  logic        issue;
  logic        ret;
  logic [2:0]  owner_oh;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    winner = 2'd0;
    if (req[1])      winner = 2'd1;
    else if (req[0]) winner = 2'd0;
    else if (req[2]) winner = 2'd2;
  end
`else
  logic [1:0] last_owner_q, last_owner_d;
  logic [1:0] cand0, cand1, cand2;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Candidates in descending priority; the later assignment wins, so the
  // checks run from lowest to highest priority.
  always_comb begin
    cand0  = inc3(last_owner_q);
    cand1  = inc3(cand0);
    cand2  = inc3(cand1);
    winner = cand0;
    if (req[cand2]) winner = cand2;
    if (req[cand1]) winner = cand1;
    if (req[cand0]) winner = cand0;
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == IDLE && |req) last_owner_d = winner;
  end

  // Reset value 2 makes fc the first requester searched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_owner_q <= 2'd2;
    else        last_owner_q <= last_owner_d;
  end
`endif

  // --------------------------------------------------------------------------
  // Burst datapath and FSM
  // --------------------------------------------------------------------------
  assign busy  = (state_q == BUSY);
  assign m_req = busy && (issued_q < beats_q);
  assign issue = m_req & m_ready;
  assign ret   = busy & ~we_q & m_rvalid;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = BUSY;
          owner_d    = winner;
          issued_d   = 9'd0;
          returned_d = 9'd0;
          case (winner)
            2'd1: begin
              we_d    = we[1];
              addr_d  = addr[53:27];
              beats_d = {1'b0, len[15:8]} + 9'd1;
            end
            2'd2: begin
              we_d    = we[2];
              addr_d  = addr[80:54];
              beats_d = {1'b0, len[23:16]} + 9'd1;
            end
            default: begin
              we_d    = we[0];
              addr_d  = addr[26:0];
              beats_d = {1'b0, len[7:0]} + 9'd1;
            end
          endcase
        end
      end
      BUSY: begin
        issued_d   = issued_q + {8'd0, issue};
        returned_d = returned_q + {8'd0, ret};
        // Use the post-update counts so a beat issued or returned this
        // cycle finishes the burst without an extra BUSY cycle.
        if (issued_d == beats_q && (we_q || returned_d == beats_q))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      we_q       <= 1'b0;
      addr_q     <= 27'd0;
      beats_q    <= 9'd0;
      issued_q   <= 9'd0;
      returned_q <= 9'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    owner_oh = 3'b000;
    case (owner_q)
      2'd1:    owner_oh = 3'b010;
      2'd2:    owner_oh = 3'b100;
      default: owner_oh = 3'b001;
    endcase
  end

  assign gnt    = busy  ? owner_oh : 3'b000;
  assign ack    = issue ? owner_oh : 3'b000;
  assign rvalid = ret   ? owner_oh : 3'b000;
  assign rdata  = m_rdata;
  assign m_we   = busy & we_q;
  assign m_addr = addr_q + {18'd0, issued_q};

  always_comb begin
    case (owner_q)
      2'd1:    m_wdata = wdata[63:32];
      2'd2:    m_wdata = wdata[95:64];
      default: m_wdata = wdata[31:0];
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A per-cycle vector
//               table covers reset, a 4-beat write, a single-beat read with
//               late return and arbitration order. Hand-written sequences
//               cover the 256-beat wrapping burst and reset mid-read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0, we = '0;
  logic [80:0] addr = '0;
  logic [23:0] len = '0;
  logic [95:0] wdata;
  logic [2:0]  gnt, ack, rvalid;
  logic [31:0] rdata;
  logic        m_req, m_we;
  logic [26:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'h5A5A_1234;

  int pass_cnt = 0;
  int total    = 0;

  localparam logic [31:0] WD0 = 32'hAAAA_0000;
  localparam logic [31:0] WD1 = 32'hBBBB_0001;
  localparam logic [31:0] WD2 = 32'hCCCC_0002;

  assign wdata = {WD2, WD1, WD0};

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .len(len),
    .wdata(wdata), .gnt(gnt), .ack(ack), .rvalid(rvalid), .rdata(rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  typedef struct {
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [26:0] a;
    logic [7:0]  l;
    logic        rdy;
    logic        rv;
    logic [2:0]  e_gnt;
    logic [2:0]  e_ack;
    logic [2:0]  e_rv;
    logic        e_mreq;
    logic        chk_a;
    logic [26:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [2:0] w,
                              input logic [26:0] a, input logic [7:0] l,
                              input logic rdy, input logic rv,
                              input logic [2:0] g, input logic [2:0] ak,
                              input logic [2:0] rvo, input logic mr,
                              input logic ca, input logic [26:0] ea);
    vec_t v;
    v.rst_n = r; v.req = rq; v.we = w; v.a = a; v.l = l; v.rdy = rdy; v.rv = rv;
    v.e_gnt = g; v.e_ack = ak; v.e_rv = rvo; v.e_mreq = mr; v.chk_a = ca;
    v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [2:0] rq, input logic [2:0] w,
                       input logic [26:0] a, input logic [7:0] l);
    req  = rq;
    we   = w;
    addr = {a, a, a};
    len  = {l, l, l};
  endtask

  function automatic logic [31:0] wd_of(input logic [2:0] g);
    case (g)
      3'b010:  return WD1;
      3'b100:  return WD2;
      default: return WD0;
    endcase
  endfunction

  logic [2:0] g1, g2, g3, g4;
  int busy_cycles, beats, addr_err, we_err;
  logic [26:0] exp_a;

  initial begin
`ifdef ARB_FIXED_PRIO_EN
    g1 = 3'b010; g2 = 3'b010; g3 = 3'b010; g4 = 3'b010;
`else
    g1 = 3'b001; g2 = 3'b010; g3 = 3'b100; g4 = 3'b001;
`endif
    //                rst req     we      addr      len rdy rv  gnt     ack     rvalid mreq chka eaddr
    vecs.push_back(mk(0, 3'b000, 3'b000, 27'h0,    0,  0, 0, 3'b000, 3'b000, 3'b000, 0, 1, 27'h0));
    vecs.push_back(mk(1, 3'b000, 3'b000, 27'h0,    0,  0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 27'h0));
    // fc 4-beat write; req dropped after sampling
    vecs.push_back(mk(1, 3'b001, 3'b001, 27'h100,  3,  1, 0, 3'b000, 3'b000, 3'b000, 0, 0, 27'h0));
    vecs.push_back(mk(1, 3'b000, 3'b001, 27'h100,  3,  1, 0, 3'b001, 3'b001, 3'b000, 1, 1, 27'h100));
    vecs.push_back(mk(1, 3'b000, 3'b001, 27'h100,  3,  1, 0, 3'b001, 3'b001, 3'b000, 1, 1, 27'h101));
    vecs.push_back(mk(1, 3'b000, 3'b001, 27'h100,  3,  1, 0, 3'b001, 3'b001, 3'b000, 1, 1, 27'h102));
    vecs.push_back(mk(1, 3'b000, 3'b001, 27'h100,  3,  1, 0, 3'b001, 3'b001, 3'b000, 1, 1, 27'h103));
    vecs.push_back(mk(1, 3'b000, 3'b000, 27'h0,    0,  1, 0, 3'b000, 3'b000, 3'b000, 0, 0, 27'h0));
    // cv single-beat read, data returns 5 cycles after the issue beat
    vecs.push_back(mk(1, 3'b010, 3'b000, 27'h20,   0,  1, 0, 3'b000, 3'b000, 3'b000, 0, 0, 27'h0));
    vecs.push_back(mk(1, 3'b010, 3'b000, 27'h20,   0,  1, 0, 3'b010, 3'b010, 3'b000, 1, 1, 27'h20));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 3'b000, 3'b000, 27'h20, 0,  1, 0, 3'b010, 3'b000, 3'b000, 0, 0, 27'h0));
    vecs.push_back(mk(1, 3'b000, 3'b000, 27'h20,   0,  1, 1, 3'b010, 3'b000, 3'b010, 0, 0, 27'h0));
    vecs.push_back(mk(1, 3'b000, 3'b000, 27'h20,   0,  1, 1, 3'b000, 3'b000, 3'b000, 0, 0, 27'h0));
    // all three requesting single-beat writes, starting from reset
    vecs.push_back(mk(0, 3'b000, 3'b000, 27'h0,    0,  1, 0, 3'b000, 3'b000, 3'b000, 0, 1, 27'h0));
    vecs.push_back(mk(1, 3'b111, 3'b111, 27'h40,   0,  1, 0, 3'b000, 3'b000, 3'b000, 0, 0, 27'h0));
    vecs.push_back(mk(1, 3'b111, 3'b111, 27'h40,   0,  1, 0, g1,     g1,     3'b000, 1, 1, 27'h40));
    vecs.push_back(mk(1, 3'b111, 3'b111, 27'h40,   0,  1, 0, 3'b000, 3'b000, 3'b000, 0, 0, 27'h0));
    vecs.push_back(mk(1, 3'b111, 3'b111, 27'h40,   0,  1, 0, g2,     g2,     3'b000, 1, 1, 27'h40));
    vecs.push_back(mk(1, 3'b111, 3'b111, 27'h40,   0,  1, 0, 3'b000, 3'b000, 3'b000, 0, 0, 27'h0));
    vecs.push_back(mk(1, 3'b111, 3'b111, 27'h40,   0,  1, 0, g3,     g3,     3'b000, 1, 1, 27'h40));
    vecs.push_back(mk(1, 3'b111, 3'b111, 27'h40,   0,  1, 0, 3'b000, 3'b000, 3'b000, 0, 0, 27'h0));
    vecs.push_back(mk(1, 3'b111, 3'b111, 27'h40,   0,  1, 0, g4,     g4,     3'b000, 1, 1, 27'h40));
    vecs.push_back(mk(1, 3'b000, 3'b000, 27'h0,    0,  1, 0, 3'b000, 3'b000, 3'b000, 0, 0, 27'h0));

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst_n    = vecs[i].rst_n;
      m_ready  = vecs[i].rdy;
      m_rvalid = vecs[i].rv;
      drive(vecs[i].req, vecs[i].we, vecs[i].a, vecs[i].l);
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i),    64'(gnt),    64'(vecs[i].e_gnt));
      chk($sformatf("v%0d_ack", i),    64'(ack),    64'(vecs[i].e_ack));
      chk($sformatf("v%0d_rvalid", i), 64'(rvalid), 64'(vecs[i].e_rv));
      chk($sformatf("v%0d_m_req", i),  64'(m_req),  64'(vecs[i].e_mreq));
      if (vecs[i].chk_a)
        chk($sformatf("v%0d_m_addr", i), 64'(m_addr), 64'(vecs[i].e_addr));
      if (vecs[i].e_mreq) begin
        chk($sformatf("v%0d_m_we", i), 64'(m_we), 64'(|(vecs[i].we & vecs[i].e_gnt)));
        if (|(vecs[i].we & vecs[i].e_gnt))
          chk($sformatf("v%0d_m_wdata", i), 64'(m_wdata), 64'(wd_of(vecs[i].e_gnt)));
      end
      if (vecs[i].e_rv != 3'b000)
        chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'(m_rdata));
    end

    // ---- mp 256-beat write from the top of the address space, m_ready 1/0
    @(posedge clk); #1;
    m_ready = 1'b1;
    drive(3'b100, 3'b100, 27'h7FF_FFFF, 8'd255);
    @(negedge clk);
    chk("long_idle_gnt", 64'(gnt), 64'(3'b000));
    busy_cycles = 0; beats = 0; addr_err = 0; we_err = 0;
    exp_a = 27'h7FF_FFFF;
    @(posedge clk);
    for (int k = 0; k < 600; k++) begin
      #1;
      m_ready = (k % 2 == 0);
      req = 3'b000;
      @(negedge clk);
      if (gnt != 3'b100) break;
      busy_cycles++;
      if (m_req && !m_we) we_err++;
      if (ack == 3'b100) begin
        if (beats == 0) chk("long_beat0_addr", 64'(m_addr), 64'(27'h7FF_FFFF));
        if (beats == 1) chk("long_wrap_addr",  64'(m_addr), 64'(27'h0));
        if (m_addr != exp_a) addr_err++;
        exp_a = exp_a + 27'd1;
        beats++;
      end
      @(posedge clk);
    end
    chk("long_acks",        64'(beats),       64'd256);
    chk("long_busy_cycles", 64'(busy_cycles), 64'd511);
    chk("long_addr_errs",   64'(addr_err),    64'd0);
    chk("long_we_errs",     64'(we_err),      64'd0);

    // ---- reset in the middle of a cv 8-beat read
    @(posedge clk); #1;
    m_ready = 1'b1;
    drive(3'b010, 3'b000, 27'h200, 8'd7);
    @(negedge clk);
    chk("rst_rd_idle_gnt", 64'(gnt), 64'(3'b000));
    @(posedge clk); #1;
    req = 3'b000;
    @(negedge clk);
    chk("rst_rd_beat0_ack",  64'(ack),    64'(3'b010));
    chk("rst_rd_beat0_addr", 64'(m_addr), 64'(27'h200));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rd_beat1_addr", 64'(m_addr), 64'(27'h201));
    @(posedge clk); #1;
    rst_n = 1'b0;
    m_rvalid = 1'b1;
    #1;
    chk("rst_gnt",    64'(gnt),    64'(3'b000));
    chk("rst_ack",    64'(ack),    64'(3'b000));
    chk("rst_rvalid", 64'(rvalid), 64'(3'b000));
    chk("rst_m_req",  64'(m_req),  64'(1'b0));
    chk("rst_m_we",   64'(m_we),   64'(1'b0));
    chk("rst_m_addr", 64'(m_addr), 64'(27'h0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("stray_rvalid", 64'(rvalid), 64'(3'b000));
    chk("stray_gnt",    64'(gnt),    64'(3'b000));
    chk("stray_m_req",  64'(m_req),  64'(1'b0));
    @(posedge clk); #1;
    m_rvalid = 1'b0;
    drive(3'b001, 3'b001, 27'h300, 8'd0);
    @(negedge clk);
    chk("post_rst_idle_gnt", 64'(gnt), 64'(3'b000));
    @(posedge clk); #1;
    req = 3'b000;
    @(negedge clk);
    chk("post_rst_gnt",     64'(gnt),     64'(3'b001));
    chk("post_rst_ack",     64'(ack),     64'(3'b001));
    chk("post_rst_m_addr",  64'(m_addr),  64'(27'h300));
    chk("post_rst_m_wdata", 64'(m_wdata), 64'(WD0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_done_gnt", 64'(gnt), 64'(3'b000));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
`default_nettype wire
